// File: rtl/wb_fifo_buf.sv
// Show-ahead single-clock FIFO buffering the FIFO-access Wishbone peripheral.
// Define WB_FIFO_BUF_THRESH_EN to add the almost_full/almost_empty outputs.
module wb_fifo_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
`ifdef WB_FIFO_BUF_THRESH_EN
    ,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2
`endif
) (
    input  logic              wb_clk,
    input  logic              wb_reset,
    input  logic              fifo_rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] d,
    output logic              wrfull,
    input  logic              rd,
    output logic [DATA_W-1:0] q,
    output logic              rdempty,
    output logic [ADDR_W:0]   usedw,
    output logic              ovf,
    output logic              unf
`ifdef WB_FIFO_BUF_THRESH_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              clr;
    logic              wr_acc;
    logic              rd_acc;

    assign clr     = wb_reset | fifo_rst;
    assign wrfull  = (count == FULL_CNT);
    assign rdempty = (count == '0);
    assign usedw   = count;
    assign rd_acc  = rd & ~rdempty;
    // A pop in the same cycle frees the slot, so a write while full still lands.
    assign wr_acc  = wr & (~wrfull | rd_acc);
    assign q       = mem[rd_ptr];

`ifdef WB_FIFO_BUF_THRESH_EN
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_CNT = (ADDR_W + 1)'(AE_LEVEL);

    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);
`endif

    // Storage is never cleared; a clear cycle only discards the write.
    always_ff @(posedge wb_clk) begin
        if (wr_acc && !clr) begin
            mem[wr_ptr] <= d;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (ADDR_W + 1)'(1);
                2'b01:   count <= count - (ADDR_W + 1)'(1);
                default: count <= count;
            endcase
            if (wr && wrfull && !rd_acc) begin
                ovf <= 1'b1;
            end
            if (rd && rdempty) begin
                unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_fifo_buf.sv
// Self-checking bench for wb_fifo_buf: queue-based reference model plus directed vectors.
module tb_wb_fifo_buf;

    logic        clk = 1'b0;
    logic        wb_reset = 1'b1;
    logic        fifo_rst = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] d = '0;
    logic [31:0] q;
    logic        wrfull;
    logic        rdempty;
    logic [4:0]  usedw;
    logic        ovf;
    logic        unf;
`ifdef WB_FIFO_BUF_THRESH_EN
    logic        almost_full;
    logic        almost_empty;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    wb_fifo_buf dut (
        .wb_clk   (clk),
        .wb_reset (wb_reset),
        .fifo_rst (fifo_rst),
        .wr       (wr),
        .d        (d),
        .wrfull   (wrfull),
        .rd       (rd),
        .q        (q),
        .rdempty  (rdempty),
        .usedw    (usedw),
        .ovf      (ovf),
        .unf      (unf)
`ifdef WB_FIFO_BUF_THRESH_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordinary queue obeying the FIFO rules.
    logic [31:0] mq[$];
    bit          m_ovf = 1'b0;
    bit          m_unf = 1'b0;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit do_rd;
        bit do_wr;
        if (wb_reset || fifo_rst) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_valid = 1'b1;
        end else begin
            do_rd = rd && (mq.size() > 0);
            do_wr = wr && ((mq.size() < 16) || do_rd);
            if (rd && mq.size() == 0) m_unf = 1'b1;
            if (wr && !do_wr) m_ovf = 1'b1;
            if (do_rd) void'(mq.pop_front());
            if (do_wr) mq.push_back(d);
        end
    end

    always @(negedge clk) begin : compare
        if (m_valid) begin
            chk("usedw",   32'(usedw),   32'(mq.size()));
            chk("rdempty", 32'(rdempty), 32'(mq.size() == 0));
            chk("wrfull",  32'(wrfull),  32'(mq.size() == 16));
            chk("ovf",     32'(ovf),     32'(m_ovf));
            chk("unf",     32'(unf),     32'(m_unf));
            if (mq.size() > 0) chk("q", q, mq[0]);
`ifdef WB_FIFO_BUF_THRESH_EN
            chk("almost_full",  32'(almost_full),  32'(mq.size() >= 12));
            chk("almost_empty", 32'(almost_empty), 32'(mq.size() <= 2));
`endif
        end
    end

    // One clock cycle with the given strobes; returns 1 ns after the edge with strobes low.
    task automatic step(input bit w, input logic [31:0] dd, input bit r, input bit rs, input bit fr);
        wr = w; d = dd; rd = r; wb_reset = rs; fifo_rst = fr;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; wb_reset = 1'b0; fifo_rst = 1'b0;
    endtask

    task automatic chk_flags(input string name, input int u, input bit e, input bit f, input bit o, input bit un);
        chk({name, "_usedw"},   32'(usedw),   32'(u));
        chk({name, "_rdempty"}, 32'(rdempty), 32'(e));
        chk({name, "_wrfull"},  32'(wrfull),  32'(f));
        chk({name, "_ovf"},     32'(ovf),     32'(o));
        chk({name, "_unf"},     32'(unf),     32'(un));
    endtask

    logic [31:0] got[$];
    logic [31:0] sent[$];

    initial begin
        @(posedge clk); #1;
        step(0, 0, 0, 1, 0);
        chk_flags("reset", 0, 1, 0, 0, 0);

        // Clear via wb_reset, with unf set beforehand
        step(0, 0, 1, 0, 0);
        chk("unf_set", 32'(unf), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 32'(i + 7), 0, 0, 0);
        chk("three_words", 32'(usedw), 32'd3);
        step(1, 32'h99, 1, 1, 0);
        chk_flags("wb_reset_clr", 0, 1, 0, 0, 0);

        // Clear via fifo_rst
        for (int i = 0; i < 3; i++) step(1, 32'(i + 20), 0, 0, 0);
        step(1, 32'h98, 0, 0, 1);
        chk_flags("fifo_rst_clr", 0, 1, 0, 0, 0);

        // Show-ahead order
        step(1, 32'h1234abcd, 0, 0, 0);
        chk("sa_first_q", q, 32'h1234abcd);
        chk("sa_not_empty", 32'(rdempty), 32'd0);
        step(1, 32'hdeadbeef, 0, 0, 0);
        step(1, 32'h00000001, 0, 0, 0);
        chk("sa_head_held", q, 32'h1234abcd);
        step(0, 0, 1, 0, 0);
        chk("sa_pop1", q, 32'hdeadbeef);
        step(0, 0, 1, 0, 0);
        chk("sa_pop2", q, 32'h00000001);
        step(0, 0, 1, 0, 0);
        chk("sa_empty", 32'(rdempty), 32'd1);

        // Full boundary
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 32'(i), 0, 0, 0);
        chk_flags("full", 16, 0, 1, 0, 0);
        step(1, 32'hffffffff, 0, 0, 0);
        chk_flags("full_drop", 16, 0, 1, 1, 0);
        chk("full_drop_q", q, 32'h0);
        step(1, 32'h55, 1, 0, 0);
        chk("full_rw_usedw", 32'(usedw), 32'd16);
        chk("full_rw_wrfull", 32'(wrfull), 32'd1);
        chk("full_rw_q", q, 32'h1);
        for (int i = 1; i < 16; i++) begin
            chk("full_drain_q", q, 32'(i));
            step(0, 0, 1, 0, 0);
        end
        chk("full_last_q", q, 32'h55);
        step(0, 0, 1, 0, 0);
        chk("full_drained", 32'(rdempty), 32'd1);

        // Empty boundary
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        chk_flags("empty_rd", 0, 1, 0, 0, 1);
        step(1, 32'ha5, 1, 0, 0);
        chk_flags("empty_rw", 1, 0, 0, 0, 1);
        chk("empty_rw_q", q, 32'ha5);

        // Wrap-around stream, occupancy kept within 1..15
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            sent.push_back(32'hc0de0000 + 32'(i));
            step(1, 32'hc0de0000 + 32'(i), 0, 0, 0);
        end
        for (int i = 4; i < 40; i++) begin
            bit r;
            r = (i % 4) != 0;
            if (r && !rdempty) got.push_back(q);
            sent.push_back(32'hc0de0000 + 32'(i));
            step(1, 32'hc0de0000 + 32'(i), r, 0, 0);
            if (usedw == 0 || usedw > 15) chk("wrap_occupancy", 32'(usedw), 32'd8);
        end
        for (int i = 0; i < 64 && !rdempty; i++) begin
            got.push_back(q);
            step(0, 0, 1, 0, 0);
        end
        chk("wrap_count", 32'(got.size()), 32'd40);
        begin
            int bad;
            bad = 0;
            foreach (got[i]) if (i < sent.size() && got[i] !== sent[i]) bad++;
            chk("wrap_order_errors", 32'(bad), 32'd0);
        end
        chk_flags("wrap_end", 0, 1, 0, 0, 0);

`ifdef WB_FIFO_BUF_THRESH_EN
        step(0, 0, 0, 1, 0);
        chk("th_reset_af", 32'(almost_full), 32'd0);
        chk("th_reset_ae", 32'(almost_empty), 32'd1);
        for (int n = 1; n <= 16; n++) begin
            step(1, 32'(n), 0, 0, 0);
            if (n == 2)  chk("th_ae_at2", 32'(almost_empty), 32'd1);
            if (n == 3)  chk("th_ae_at3", 32'(almost_empty), 32'd0);
            if (n == 11) chk("th_af_at11", 32'(almost_full), 32'd0);
            if (n == 12) chk("th_af_at12", 32'(almost_full), 32'd1);
        end
`endif

        step(0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_fifo_buf.md
Name: wb_fifo_buf

Overview:
- Single-clock, show-ahead synchronous FIFO. It is the buffer directly attached to the FIFO-access Wishbone peripheral.
- Two instances are used. One takes that peripheral's output-FIFO write port (of_d/of_wr/of_wrfull). The other feeds its input-FIFO read port (if_d/if_rd/if_rdempty).
- Head word is presented combinationally so the peripheral can sample read data in the same cycle it issues the read strobe.
- Both instances are cleared by the peripheral's fifo_rst control bit.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 4, log2 of depth; depth = 2**ADDR_W (16 words).
- AF_LEVEL, 12, almost-full threshold in words (optional feature only).
- AE_LEVEL, 2, almost-empty threshold in words (optional feature only).

Ports:
- wb_clk  in  1  clock; all logic on rising edge.
- wb_reset  in  1  reset, synchronous, active-high.
- fifo_rst  in  1  synchronous clear, active-high; same effect as wb_reset.
- wr  in  1  write strobe.
- d  in  DATA_W  write data.
- wrfull  out  1  FIFO full.
- rd  in  1  read/acknowledge strobe; pops the head word.
- q  out  DATA_W  head word (show-ahead); valid while rdempty=0.
- rdempty  out  1  FIFO empty.
- usedw  out  ADDR_W+1  word count, 0..2**ADDR_W.
- ovf  out  1  sticky: a write was attempted while full.
- unf  out  1  sticky: a read was attempted while empty.

Behaviour:
- Storage and pointers
  - Storage is a 2**ADDR_W x DATA_W array.
  - wr_ptr and rd_ptr are ADDR_W bits wide and wrap modulo depth.
  - count is ADDR_W+1 bits wide.
- Reset
  - On wb_reset=1 or fifo_rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, count=0, ovf=0, unf=0.
  - Outputs after reset: rdempty=1, wrfull=0, usedw=0. q is don't-care; it is not required to be zero.
  - Clear has priority over wr/rd in the same cycle; those strobes are discarded.
  - Memory contents are not cleared.
- Status derivation
  - Registered count is the single source: wrfull = (count == 2**ADDR_W), rdempty = (count == 0), usedw = count.
  - All flags are combinational decodes of count, so no flag glitches on strobes.
- Write acceptance
  - wr_acc = wr & (~wrfull | rd_acc).
  - On acceptance: mem[wr_ptr] <= d, wr_ptr++.
- Read acceptance
  - rd_acc = rd & ~rdempty.
  - On acceptance: rd_ptr++.
- Count update
  - count += wr_acc - rd_acc.
  - Simultaneous accepted read and write leaves count unchanged.
- Full boundary
  - Write and read together while full are both accepted; count stays at depth and wrfull stays 1.
  - Write while full without read is dropped; ovf is set and held until clear.
- Empty boundary
  - Read and write together while empty: the read is ignored, unf is set, and the write is accepted.
  - The result is count=1, with rdempty falling next cycle.
  - Read while empty, alone, sets unf and changes no state.
- Show-ahead output
  - q = mem[rd_ptr], read asynchronously from distributed RAM.
- Latency
  - A word written at edge N appears on q and deasserts rdempty after edge N, i.e. usable in cycle N+1.
  - A pop at edge N exposes the next word on q in cycle N+1.
- Wrap-around
  - Pointers wrap 15→0 with no bubble.
  - Data order is preserved across any number of wraps.
- Strobe timing
  - rd and wr are level-sampled every cycle.
  - The upstream peripheral guarantees single-cycle pulses; back-to-back pulses are legal and each is acted on.

Optional Feature:
- Macro: WB_FIFO_BUF_THRESH_EN.
- When defined, two extra outputs exist:
  - almost_full out 1 = (count >= AF_LEVEL).
  - almost_empty out 1 = (count <= AE_LEVEL).
  - Both are decoded from registered count, and both reset/clear to almost_full=0, almost_empty=1.
- When undefined, these ports and the AF_LEVEL/AE_LEVEL logic are absent.
- Core FIFO behaviour is identical in both builds.

Test Plan:
- Reset/clear
  - Stimulus: write 3 words, then pulse wb_reset 1 cycle; repeat using fifo_rst.
  - Required: next cycle usedw=0, rdempty=1, wrfull=0, ovf=unf=0.
- Show-ahead order
  - Stimulus: write 0x1234abcd, 0xdeadbeef, 0x00000001 on consecutive cycles.
  - Required: q=0x1234abcd one cycle after the first write. Three rd pulses yield 0xdeadbeef, then 0x00000001 on q. rdempty=1 after the third pop.
- Full boundary
  - Stimulus: write 16 words (values 0..15), then write 0xffffffff alone.
  - Required: wrfull=1, usedw=16, word dropped, ovf=1.
  - Then assert rd+wr with d=0x55 in one cycle. Required: usedw stays 16, q=1, and 0x55 is later read out last.
- Empty boundary
  - Stimulus: rd alone while empty. Required: unf=1, usedw=0.
  - Then rd+wr together with d=0xa5. Required: usedw=1, q=0xa5, rdempty=0.
- Wrap-around
  - Stimulus: 40 words streamed with interleaved reads, occupancy held 1..15.
  - Required: output sequence identical to input, no ovf/unf, pointers wrap at least twice.
- Thresholds (WB_FIFO_BUF_THRESH_EN)
  - Stimulus: fill 0→16 one word per cycle.
  - Required: almost_empty drops when usedw=3; almost_full rises when usedw=12.
  - Also build without the macro and confirm it compiles with the ports absent.
